sd_cmd_resp_rx: RTL and testbench

//  Receives SD/SDIO responses on the CMD line, downstream of the command transmitter.

---
 rtl/sd_cmd_resp_rx.sv | 140 ++++++++++++++
 tb/tb_sd_cmd_resp_rx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_resp_rx.sv
// SD/SDIO CMD-line response receiver: waits for the card start bit, shifts in a
// 48- or 136-bit response, checks framing/CRC7 and holds it for a valid/ready consumer.
//
// state      | meaning
// IDLE       | waiting for arm from the command transmitter
// WAIT_START | CMD released, counting strobes until the card start bit
// RECV       | shifting response bits in, MSB first
// DONE       | response/status presented, waiting for resp_ready
module sd_cmd_resp_rx #(
    parameter int TIMEOUT_CLKS = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sample_en,
    input  logic         cmd_in,
    input  logic         arm,
    input  logic         long_resp,
    input  logic         no_crc,
    input  logic         resp_ready,
    output logic         busy,
    output logic         resp_valid,
    output logic [5:0]   resp_index,
    output logic [127:0] resp_payload,
    output logic         crc_err,
    output logic         frame_err,
    output logic         timeout
);

    localparam int TW = $clog2(TIMEOUT_CLKS + 1);

    typedef enum logic [1:0] {IDLE, WAIT_START, RECV, DONE} state_t;

    state_t         state;
    logic [133:0]   sr;
    logic [7:0]     bit_cnt;
    logic [TW-1:0]  tmo_cnt;
    logic           long_q;
    logic           no_crc_q;
    logic [6:0]     crc;

    logic [7:0]     bit_idx;
    logic           crc_use;
    logic           crc_fb;
    logic [6:0]     crc_next;
    logic [133:0]   sr_next;

    // bit_idx is the frame position of the bit sampled on this strobe
    always_comb begin
        bit_idx  = bit_cnt - 8'd1;
        crc_use  = (bit_idx >= 8'd8) && (!long_q || (bit_idx <= 8'd127));
        crc_fb   = crc[6] ^ cmd_in;
        crc_next = {crc[5:0], 1'b0} ^ (crc_fb ? 7'h09 : 7'h00);
        sr_next  = {sr[132:0], cmd_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            sr           <= '0;
            bit_cnt      <= '0;
            tmo_cnt      <= '0;
            long_q       <= 1'b0;
            no_crc_q     <= 1'b0;
            crc          <= '0;
            busy         <= 1'b0;
            resp_valid   <= 1'b0;
            resp_index   <= '0;
            resp_payload <= '0;
            crc_err      <= 1'b0;
            frame_err    <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arm) begin
                        state    <= WAIT_START;
                        long_q   <= long_resp;
                        no_crc_q <= no_crc;
                        tmo_cnt  <= '0;
                        crc      <= '0;
                        sr       <= '0;
                        busy     <= 1'b1;
                    end
                end
                WAIT_START: begin
                    if (sample_en) begin
                        if (!cmd_in) begin
                            state   <= RECV;
                            bit_cnt <= long_q ? 8'd135 : 8'd47;
                        end else if (tmo_cnt == TW'(TIMEOUT_CLKS - 1)) begin
                            state        <= DONE;
                            tmo_cnt      <= tmo_cnt + 1'b1;
                            resp_valid   <= 1'b1;
                            timeout      <= 1'b1;
                            resp_index   <= '0;
                            resp_payload <= '0;
                            crc_err      <= 1'b0;
                            frame_err    <= 1'b0;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (sample_en) begin
                        sr      <= sr_next;
                        bit_cnt <= bit_cnt - 8'd1;
                        if (crc_use)
                            crc <= crc_next;
                        if (bit_cnt == 8'd1) begin
                            // end bit: sr still holds frame[k] at sr[k-1]
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            timeout    <= 1'b0;
                            crc_err    <= (crc != sr[6:0]) && !no_crc_q;
                            if (long_q) begin
                                resp_index   <= sr[132:127];
                                resp_payload <= {sr[126:0], cmd_in};
                                frame_err    <= sr[133] || !cmd_in;
                            end else begin
                                resp_index   <= sr[44:39];
                                resp_payload <= {96'h0, sr[38:7]};
                                frame_err    <= sr[45] || !cmd_in;
                            end
                        end
                    end
                end
                DONE: begin
                    if (resp_valid && resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_resp_rx.sv
// Directed bench for sd_cmd_resp_rx: bit-serial CMD frames with bench-built CRC7,
// timeout edge, handshake hold, arm collisions and async reset mid-frame.
module tb_sd_cmd_resp_rx;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sample_en = 1'b0;
    logic         cmd_in = 1'b1;
    logic         arm = 1'b0;
    logic         long_resp = 1'b0;
    logic         no_crc = 1'b0;
    logic         resp_ready = 1'b0;
    logic         busy;
    logic         resp_valid;
    logic [5:0]   resp_index;
    logic [127:0] resp_payload;
    logic         crc_err;
    logic         frame_err;
    logic         timeout;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    sd_cmd_resp_rx #(.TIMEOUT_CLKS(64)) dut (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .cmd_in(cmd_in),
        .arm(arm), .long_resp(long_resp), .no_crc(no_crc), .resp_ready(resp_ready),
        .busy(busy), .resp_valid(resp_valid), .resp_index(resp_index),
        .resp_payload(resp_payload), .crc_err(crc_err), .frame_err(frame_err),
        .timeout(timeout)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // x^7+x^3+1, init 0, over f[hi] down to f[lo]
    function automatic logic [6:0] crc7(input logic [135:0] f, input int hi, input int lo);
        logic [6:0] c = 7'h0;
        logic fb;
        for (int i = hi; i >= lo; i--) begin
            fb = c[6] ^ f[i];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    // one strobe; cmd_in is scrambled between strobes to show it is ignored
    task automatic strobe(input logic b);
        @(negedge clk);
        cmd_in = b; sample_en = 1'b1;
        @(negedge clk);
        sample_en = 1'b0; cmd_in = ~b;
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [135:0] f, input int len);
        for (int i = len - 1; i >= 0; i--) strobe(f[i]);
        cmd_in = 1'b1;
    endtask

    task automatic do_arm(input logic lr, input logic nc);
        @(negedge clk);
        arm = 1'b1; long_resp = lr; no_crc = nc;
        @(negedge clk);
        arm = 1'b0; long_resp = 1'b0; no_crc = 1'b0;
    endtask

    task automatic ack(input string tag);
        @(negedge clk);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk({tag, "_ack_valid"}, resp_valid, 1'b0);
        chk({tag, "_ack_busy"}, busy, 1'b0);
    endtask

    function automatic logic [135:0] short_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [135:0] f = '0;
        f[47:0] = {1'b0, 1'b0, idx, arg, 7'h00, 1'b1};
        f[7:1]  = crc7(f, 47, 8);
        return f;
    endfunction

    logic [135:0] fr;
    logic [119:0] cid;
    logic [127:0] held_payload;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_valid", resp_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_payload", resp_payload, 128'h0);
        rst_n = 1'b1;

        // 1: R1 to CMD55
        do_arm(1'b0, 1'b0);
        chk("r1_busy_armed", busy, 1'b1);
        fr = short_frame(6'd55, 32'h0000_0120);
        send_frame(fr, 48);
        chk("r1_valid", resp_valid, 1'b1);
        chk("r1_index", resp_index, 6'd55);
        chk("r1_payload", resp_payload, 128'h120);
        chk("r1_crc_err", crc_err, 1'b0);
        chk("r1_frame_err", frame_err, 1'b0);
        chk("r1_timeout", timeout, 1'b0);
        ack("r1");

        // 2: arg bit 5 flipped, stale CRC
        do_arm(1'b0, 1'b0);
        fr[13] = ~fr[13];
        send_frame(fr, 48);
        chk("r1bad_crc_err", crc_err, 1'b1);
        chk("r1bad_payload", resp_payload, 128'h100);
        chk("r1bad_frame_err", frame_err, 1'b0);
        ack("r1bad");

        // bad end bit: framing error, CRC still fine
        do_arm(1'b0, 1'b0);
        fr = short_frame(6'd17, 32'hDEAD_BEEF);
        fr[0] = 1'b0;
        send_frame(fr, 48);
        chk("endbit_frame_err", frame_err, 1'b1);
        chk("endbit_crc_err", crc_err, 1'b0);
        chk("endbit_payload", resp_payload, 128'hDEAD_BEEF);
        ack("endbit");

        // 3: R3, no CRC check
        do_arm(1'b0, 1'b1);
        fr = '0;
        fr[47:0] = {1'b0, 1'b0, 6'h3F, 32'h80FF_8000, 7'h7F, 1'b1};
        send_frame(fr, 48);
        chk("r3_index", resp_index, 6'h3F);
        chk("r3_payload", resp_payload, 128'h80FF_8000);
        chk("r3_crc_err", crc_err, 1'b0);
        chk("r3_frame_err", frame_err, 1'b0);
        ack("r3");

        // 4: R2 long response with CID
        cid = 120'h0123456789ABCDEF_FEDCBA987654EF;
        fr = {1'b0, 1'b0, 6'h3F, cid, 7'h00, 1'b1};
        fr[7:1] = crc7(fr, 127, 8);
        do_arm(1'b1, 1'b0);
        send_frame(fr, 136);
        chk("r2_valid", resp_valid, 1'b1);
        chk("r2_index", resp_index, 6'h3F);
        chk("r2_payload", resp_payload, fr[127:0]);
        chk("r2_crc_err", crc_err, 1'b0);
        chk("r2_frame_err", frame_err, 1'b0);

        // 6a: hold unaccepted response for 20 clks, arm pulsed meanwhile
        held_payload = resp_payload;
        repeat (10) @(negedge clk);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        repeat (9) @(negedge clk);
        chk("hold_valid", resp_valid, 1'b1);
        chk("hold_payload", resp_payload, held_payload);
        chk("hold_index", resp_index, 6'h3F);
        chk("hold_busy", busy, 1'b1);
        // arm coincident with the handshake is dropped
        @(negedge clk);
        resp_ready = 1'b1; arm = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0; arm = 1'b0;
        chk("collide_valid", resp_valid, 1'b0);
        chk("collide_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        chk("collide_still_idle", busy, 1'b0);

        // 5: timeout exactly at the 64th idle strobe
        do_arm(1'b0, 1'b0);
        for (int i = 0; i < 63; i++) strobe(1'b1);
        chk("tmo_not_yet", resp_valid, 1'b0);
        chk("tmo_busy", busy, 1'b1);
        strobe(1'b1);
        chk("tmo_valid", resp_valid, 1'b1);
        chk("tmo_flag", timeout, 1'b1);
        chk("tmo_payload", resp_payload, 128'h0);
        chk("tmo_index", resp_index, 6'h0);
        chk("tmo_crc_err", crc_err, 1'b0);
        chk("tmo_frame_err", frame_err, 1'b0);
        ack("tmo");

        // start bit on strobe 63 is still accepted
        do_arm(1'b0, 1'b0);
        for (int i = 0; i < 62; i++) strobe(1'b1);
        fr = short_frame(6'd8, 32'h0000_01AA);
        send_frame(fr, 48);
        chk("late_timeout", timeout, 1'b0);
        chk("late_valid", resp_valid, 1'b1);
        chk("late_index", resp_index, 6'd8);
        chk("late_payload", resp_payload, 128'h1AA);
        chk("late_crc_err", crc_err, 1'b0);
        ack("late");

        // 6b: async reset mid-RECV
        do_arm(1'b0, 1'b0);
        fr = short_frame(6'd2, 32'h1234_5678);
        for (int i = 47; i >= 30; i--) strobe(fr[i]);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_valid", resp_valid, 1'b0);
        chk("midrst_payload", resp_payload, 128'h0);
        chk("midrst_index", resp_index, 6'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 29; i >= 0; i--) strobe(fr[i]);
        chk("midrst_no_partial", resp_valid, 1'b0);

        // clean frame after reset
        do_arm(1'b0, 1'b0);
        send_frame(fr, 48);
        chk("post_rst_index", resp_index, 6'd2);
        chk("post_rst_payload", resp_payload, 128'h1234_5678);
        chk("post_rst_crc_err", crc_err, 1'b0);
        ack("post_rst");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
